// File: rtl/uart_pkg.sv
// Shared UART definitions for the correlator host link: bit timing helper, FSM state
// encodings, the frame sync marker and control-register addresses.
package uart_pkg;

    localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;

    // Correlator control-register map, shared with the register block and TX side
    localparam logic [7:0] REG_INTEG_LEN  = 8'h10;
    localparam logic [7:0] REG_SAMPLE_DIV = 8'h01;
    localparam logic [7:0] REG_DELAY_TAP  = 8'h02;

    typedef enum logic [2:0] {
        BitIdle,
        BitStart,
        BitData,
        BitStop,
        BitWaitHigh
    } bit_state_e;

    typedef enum logic [2:0] {
        PsSync,
        PsAddr,
        PsDhi,
        PsDlo,
        PsChk
    } parse_state_e;

    function automatic int unsigned clks_per_bit(input int unsigned clk_freq,
                                                 input int unsigned baud);
        return clk_freq / baud;
    endfunction

endpackage

// File: rtl/uart_rx_byte.sv
// 8N1 UART byte receiver: 2-flop synchroniser, mid-bit sampling bit FSM, registered
// byte_valid/frame_err pulses.
module uart_rx_byte
    import uart_pkg::*;
#(
    parameter int unsigned ClksPerBit = 25
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       rx_i,
    output logic       byte_valid_o,
    output logic [7:0] byte_data_o,
    output logic       frame_err_o
);
    localparam int unsigned    CntW     = $clog2(ClksPerBit);
    localparam logic [CntW-1:0] HalfLoad = CntW'(ClksPerBit / 2 - 1);
    localparam logic [CntW-1:0] FullLoad = CntW'(ClksPerBit - 1);

    bit_state_e      state_q;
    logic            rx_meta_q, rx_sync_q, rx_prev_q;
    logic [CntW-1:0] cnt_q;
    logic [2:0]      bit_idx_q;
    logic [7:0]      shift_q;
    logic [7:0]      byte_data_q;
    logic            byte_valid_q, frame_err_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rx_meta_q    <= 1'b1;
            rx_sync_q    <= 1'b1;
            rx_prev_q    <= 1'b1;
            state_q      <= BitIdle;
            cnt_q        <= '0;
            bit_idx_q    <= '0;
            shift_q      <= '0;
            byte_data_q  <= '0;
            byte_valid_q <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            rx_meta_q    <= rx_i;
            rx_sync_q    <= rx_meta_q;
            rx_prev_q    <= rx_sync_q;
            byte_valid_q <= 1'b0;
            frame_err_q  <= 1'b0;
            case (state_q)
                BitIdle: begin
                    if (rx_prev_q && !rx_sync_q) begin
                        cnt_q   <= HalfLoad;
                        state_q <= BitStart;
                    end
                end
                BitStart: begin
                    if (cnt_q == '0) begin
                        // A start bit that is high again at mid-bit was a line glitch
                        if (!rx_sync_q) begin
                            cnt_q     <= FullLoad;
                            bit_idx_q <= '0;
                            state_q   <= BitData;
                        end else begin
                            state_q <= BitIdle;
                        end
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                BitData: begin
                    if (cnt_q == '0) begin
                        shift_q <= {rx_sync_q, shift_q[7:1]};
                        cnt_q   <= FullLoad;
                        if (bit_idx_q == 3'd7) begin
                            state_q <= BitStop;
                        end else begin
                            bit_idx_q <= bit_idx_q + 1'b1;
                        end
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                BitStop: begin
                    if (cnt_q == '0) begin
                        if (rx_sync_q) begin
                            byte_valid_q <= 1'b1;
                            byte_data_q  <= shift_q;
                            state_q      <= BitIdle;
                        end else begin
                            frame_err_q <= 1'b1;
                            state_q     <= BitWaitHigh;
                        end
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                BitWaitHigh: begin
                    if (rx_sync_q) begin
                        state_q <= BitIdle;
                    end
                end
                default: state_q <= BitIdle;
            endcase
        end
    end

    assign byte_valid_o = byte_valid_q;
    assign byte_data_o  = byte_data_q;
    assign frame_err_o  = frame_err_q;

endmodule

// File: rtl/uart_cmd_rx.sv
// Host-link command receiver: parses sync/addr/data/checksum frames from the UART byte
// stream into single-cycle register-write strobes, with an inter-byte timeout.
module uart_cmd_rx
    import uart_pkg::*;
#(
    parameter int unsigned CLK_FREQUENCY = 50000000,
    parameter int unsigned BAUD_RATE     = 2000000,
    parameter logic [7:0]  SYNC_BYTE     = SYNC_BYTE_DEFAULT,
    parameter int unsigned TIMEOUT_BITS  = 40
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        rx_i,
    output logic        byte_valid_o,
    output logic [7:0]  byte_data_o,
    output logic        cmd_valid_o,
    output logic [7:0]  cmd_addr_o,
    output logic [15:0] cmd_data_o,
    output logic        frame_err_o,
    output logic        cmd_err_o
);
    localparam int unsigned     ClksPerBit = clks_per_bit(CLK_FREQUENCY, BAUD_RATE);
    localparam int unsigned     TmoCycles  = TIMEOUT_BITS * ClksPerBit;
    localparam int unsigned     TmoW       = $clog2(TmoCycles);
    // Counter starts one cycle after byte_valid and the pulse is registered, so fire two
    // counts early to land the pulse exactly TmoCycles after byte_valid.
    localparam logic [TmoW-1:0] TmoFire    = TmoW'(TmoCycles - 2);

    parse_state_e    ps_q;
    logic [7:0]      addr_sh_q, dhi_sh_q, dlo_sh_q;
    logic [TmoW-1:0] tmo_q;
    logic            cmd_valid_q, cmd_err_q;
    logic [7:0]      cmd_addr_q;
    logic [15:0]     cmd_data_q;

    uart_rx_byte #(
        .ClksPerBit(ClksPerBit)
    ) u_rx_byte (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .rx_i        (rx_i),
        .byte_valid_o(byte_valid_o),
        .byte_data_o (byte_data_o),
        .frame_err_o (frame_err_o)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ps_q        <= PsSync;
            addr_sh_q   <= '0;
            dhi_sh_q    <= '0;
            dlo_sh_q    <= '0;
            tmo_q       <= '0;
            cmd_valid_q <= 1'b0;
            cmd_err_q   <= 1'b0;
            cmd_addr_q  <= '0;
            cmd_data_q  <= '0;
        end else begin
            cmd_valid_q <= 1'b0;
            cmd_err_q   <= 1'b0;
            if (byte_valid_o) begin
                tmo_q <= '0;
                case (ps_q)
                    PsSync: begin
                        if (byte_data_o == SYNC_BYTE) begin
                            ps_q <= PsAddr;
                        end
                    end
                    PsAddr: begin
                        addr_sh_q <= byte_data_o;
                        ps_q      <= PsDhi;
                    end
                    PsDhi: begin
                        dhi_sh_q <= byte_data_o;
                        ps_q     <= PsDlo;
                    end
                    PsDlo: begin
                        dlo_sh_q <= byte_data_o;
                        ps_q     <= PsChk;
                    end
                    PsChk: begin
                        if (byte_data_o == (addr_sh_q ^ dhi_sh_q ^ dlo_sh_q)) begin
                            cmd_valid_q <= 1'b1;
                            cmd_addr_q  <= addr_sh_q;
                            cmd_data_q  <= {dhi_sh_q, dlo_sh_q};
                        end else begin
                            cmd_err_q <= 1'b1;
                        end
                        ps_q <= PsSync;
                    end
                    default: ps_q <= PsSync;
                endcase
            end else if (ps_q == PsSync) begin
                tmo_q <= '0;
            end else if (tmo_q == TmoFire) begin
                cmd_err_q <= 1'b1;
                ps_q      <= PsSync;
                tmo_q     <= '0;
            end else begin
                tmo_q <= tmo_q + 1'b1;
            end
        end
    end

    assign cmd_valid_o = cmd_valid_q;
    assign cmd_err_o   = cmd_err_q;
    assign cmd_addr_o  = cmd_addr_q;
    assign cmd_data_o  = cmd_data_q;

endmodule

// File: tb/tb_uart_cmd_rx.sv
// Bench for uart_cmd_rx: drives RX as a 2 Mbaud line and checks every output pulse and
// held value against a queue-based frame model.
module tb_uart_cmd_rx;
    localparam int CPB     = 25;
    localparam int TMO_CYC = 1000;
    localparam int EvByte  = 0;
    localparam int EvCmd   = 1;
    localparam int EvFerr  = 2;
    localparam int EvCerr  = 3;

    typedef struct {
        int          kind;
        logic [7:0]  b;
        logic [7:0]  a;
        logic [15:0] d;
        bit          tmo;
    } ev_t;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        rx_i;
    logic        byte_valid_o, cmd_valid_o, frame_err_o, cmd_err_o;
    logic [7:0]  byte_data_o, cmd_addr_o;
    logic [15:0] cmd_data_o;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int last_bv_cyc = 0;
    int n_bv = 0, n_cv = 0, n_fe = 0, n_ce = 0;

    ev_t        exp_q[$];
    logic [7:0] frm[$];
    logic [7:0]  exp_bd = 8'h00;
    logic [7:0]  exp_a  = 8'h00;
    logic [15:0] exp_d  = 16'h0000;

    uart_cmd_rx dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .rx_i        (rx_i),
        .byte_valid_o(byte_valid_o),
        .byte_data_o (byte_data_o),
        .cmd_valid_o (cmd_valid_o),
        .cmd_addr_o  (cmd_addr_o),
        .cmd_data_o  (cmd_data_o),
        .frame_err_o (frame_err_o),
        .cmd_err_o   (cmd_err_o)
    );

    always #10 clk_i = ~clk_i;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
        end
    endtask

    // ---------------- model ----------------
    task automatic push_ev(input int kind, input logic [7:0] b, input logic [7:0] a,
                           input logic [15:0] d, input bit tmo);
        ev_t e;
        e.kind = kind; e.b = b; e.a = a; e.d = d; e.tmo = tmo;
        exp_q.push_back(e);
    endtask

    task automatic model_byte(input logic [7:0] b);
        push_ev(EvByte, b, 8'h00, 16'h0000, 1'b0);
        if (frm.size() == 0) begin
            if (b == 8'hA5) frm.push_back(b);
        end else begin
            frm.push_back(b);
            if (frm.size() == 5) begin
                if ((frm[1] ^ frm[2] ^ frm[3]) == frm[4])
                    push_ev(EvCmd, 8'h00, frm[1], {frm[2], frm[3]}, 1'b0);
                else
                    push_ev(EvCerr, 8'h00, 8'h00, 16'h0000, 1'b0);
                frm.delete();
            end
        end
    endtask

    task automatic model_timeout();
        if (frm.size() != 0) push_ev(EvCerr, 8'h00, 8'h00, 16'h0000, 1'b1);
        frm.delete();
    endtask

    // ---------------- compare process ----------------
    task automatic take(input int kind, output ev_t ev, output bit ok);
        ok = 1'b0;
        ev.kind = -1; ev.b = '0; ev.a = '0; ev.d = '0; ev.tmo = 1'b0;
        if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_pulse kind=%0d actual=pulse required=none", kind);
        end else begin
            ev = exp_q.pop_front();
            chk("event_kind", kind, ev.kind);
            ok = (ev.kind == kind);
        end
    endtask

    always @(negedge clk_i) begin
        ev_t e;
        bit  ok;
        cyc++;
        if (rst_i) begin
            exp_bd = 8'h00;
            exp_a  = 8'h00;
            exp_d  = 16'h0000;
            chk("reset_pulses", {byte_valid_o, cmd_valid_o, frame_err_o, cmd_err_o}, 0);
        end else begin
            if (byte_valid_o) begin
                n_bv++;
                take(EvByte, e, ok);
                if (ok) exp_bd = e.b;
                last_bv_cyc = cyc;
            end
            if (frame_err_o) begin
                n_fe++;
                take(EvFerr, e, ok);
            end
            if (cmd_valid_o) begin
                n_cv++;
                take(EvCmd, e, ok);
                if (ok) begin
                    exp_a = e.a;
                    exp_d = e.d;
                end
            end
            if (cmd_err_o) begin
                n_ce++;
                take(EvCerr, e, ok);
                if (ok && e.tmo) chk("timeout_cycle", cyc - last_bv_cyc, TMO_CYC);
            end
            chk("byte_data", byte_data_o, exp_bd);
            chk("cmd_addr", cmd_addr_o, exp_a);
            chk("cmd_data", cmd_data_o, exp_d);
        end
    end

    // ---------------- stimulus ----------------
    task automatic line_bit(input logic v);
        rx_i = v;
        repeat (CPB) @(negedge clk_i);
    endtask

    task automatic send_byte(input logic [7:0] b, input bit stop_ok, input int gap);
        if (stop_ok) model_byte(b);
        else push_ev(EvFerr, 8'h00, 8'h00, 16'h0000, 1'b0);
        line_bit(1'b0);
        for (int i = 0; i < 8; i++) line_bit(b[i]);
        line_bit(stop_ok);
        rx_i = 1'b1;
        repeat (gap) @(negedge clk_i);
    endtask

    task automatic send_frame(input logic [7:0] a, input logic [7:0] dh, input logic [7:0] dl,
                              input logic [7:0] c, input int gap);
        send_byte(8'hA5, 1'b1, gap);
        send_byte(a, 1'b1, gap);
        send_byte(dh, 1'b1, gap);
        send_byte(dl, 1'b1, gap);
        send_byte(c, 1'b1, gap);
    endtask

    task automatic drain();
        for (int i = 0; i < 3000 && exp_q.size() != 0; i++) @(negedge clk_i);
        chk("drain_pending_events", exp_q.size(), 0);
        repeat (3) @(negedge clk_i);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int b_cv, b_ce, b_fe, b_bv;
        logic [7:0] a, dh, dl, c, junk;
        rx_i  = 1'b1;
        rst_i = 1'b0;
        #1 rst_i = 1'b1;
        repeat (5) @(posedge clk_i);
        #3 rst_i = 1'b0;
        repeat (20) @(negedge clk_i);
        chk("reset_byte_data", byte_data_o, 8'h00);
        chk("reset_cmd_data", cmd_data_o, 16'h0000);

        // 1: valid frame
        b_cv = n_cv; b_ce = n_ce;
        send_frame(8'h10, 8'h12, 8'h34, 8'h36, 4);
        drain();
        chk("t1_cmd_count", n_cv - b_cv, 1);
        chk("t1_err_count", n_ce - b_ce, 0);
        chk("t1_addr", cmd_addr_o, 8'h10);
        chk("t1_data", cmd_data_o, 16'h1234);

        // 2: bad checksum then back-to-back valid frame
        b_cv = n_cv; b_ce = n_ce;
        send_frame(8'h10, 8'h12, 8'h34, 8'h37, 0);
        drain();
        chk("t2_err_count", n_ce - b_ce, 1);
        chk("t2_no_cmd", n_cv - b_cv, 0);
        send_frame(8'h01, 8'h00, 8'hFF, 8'hFE, 0);
        drain();
        chk("t2_addr", cmd_addr_o, 8'h01);
        chk("t2_data", cmd_data_o, 16'h00FF);

        // 3: framing error then held break
        b_fe = n_fe; b_bv = n_bv;
        send_byte(8'h55, 1'b0, 0);
        rx_i = 1'b0;
        repeat (200) @(negedge clk_i);
        rx_i = 1'b1;
        repeat (100) @(negedge clk_i);
        drain();
        chk("t3_ferr_count", n_fe - b_fe, 1);
        chk("t3_no_byte", n_bv - b_bv, 0);
        chk("t3_byte_hold", byte_data_o, 8'hFE);

        // 4: idle glitch then a clean byte
        b_fe = n_fe;
        rx_i = 1'b0;
        repeat (8) @(negedge clk_i);
        rx_i = 1'b1;
        repeat (60) @(negedge clk_i);
        send_byte(8'hC3, 1'b1, 10);
        drain();
        chk("t4_byte", byte_data_o, 8'hC3);
        chk("t4_no_ferr", n_fe - b_fe, 0);

        // 5: inter-byte timeout then recovery
        b_ce = n_ce;
        send_byte(8'hA5, 1'b1, 2);
        send_byte(8'h20, 1'b1, 0);
        model_timeout();
        repeat (1100) @(negedge clk_i);
        drain();
        chk("t5_tmo_count", n_ce - b_ce, 1);
        send_frame(8'h03, 8'h55, 8'hAA, 8'hFC, 3);
        drain();
        chk("t5_addr", cmd_addr_o, 8'h03);
        chk("t5_data", cmd_data_o, 16'h55AA);

        // 6: reset in the middle of the third byte
        send_byte(8'hA5, 1'b1, 0);
        send_byte(8'h10, 1'b1, 0);
        drain();
        line_bit(1'b0);
        line_bit(1'b1);
        line_bit(1'b0);
        @(posedge clk_i);
        #3 rst_i = 1'b1;
        rx_i = 1'b1;
        repeat (3) @(posedge clk_i);
        #3 rst_i = 1'b0;
        frm.delete();
        repeat (100) @(negedge clk_i);
        chk("t6_reset_byte", byte_data_o, 8'h00);
        b_cv = n_cv;
        send_frame(8'h02, 8'hAB, 8'hCD, 8'h64, 1);
        drain();
        chk("t6_cmd_count", n_cv - b_cv, 1);
        chk("t6_addr", cmd_addr_o, 8'h02);
        chk("t6_data", cmd_data_o, 16'hABCD);

        // randomized frames, junk bytes in SYNC, occasional bad checksums
        for (int f = 0; f < 20; f++) begin
            if ($urandom_range(0, 3) == 0) begin
                junk = 8'($urandom);
                if (junk == 8'hA5) junk = 8'h5A;
                send_byte(junk, 1'b1, $urandom_range(0, 30));
            end
            a  = 8'($urandom);
            dh = ($urandom_range(0, 4) == 0) ? 8'hA5 : 8'($urandom);
            dl = 8'($urandom);
            c  = a ^ dh ^ dl;
            if ($urandom_range(0, 3) == 0) c = c ^ 8'($urandom_range(1, 255));
            send_frame(a, dh, dl, c, $urandom_range(0, 30));
        end
        drain();
        repeat (50) @(negedge clk_i);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
